// File: rtl/camera_init_sequencer.sv
// camera_init_sequencer
//
// Power-up and register-configuration sequencer for the image sensor.
// After start_i it holds the sensor in reset, waits for power-up, then walks
// a register table in a synchronous ROM.
// Each WRITE entry goes to the SCCB master over a valid/ready handshake.
// DELAY entries stall for a multiple of DELAY_UNIT_CYCLES.
// An END entry starts the frame-settle phase. Once SETTLE_FRAMES vsync falling
// edges have been seen, capture is enabled and done_o is raised.
//
// Optional feature macro: CAMERA_INIT_RETRY_EN
//   defined   - a NACKed write is re-issued up to MAX_RETRIES times.
//   undefined - the first NACK aborts the sequence (no retry counter).
//
// Ports:
//   clk_i, rst_i             system clock, synchronous active-high reset
//   start_i                  start pulse (honoured in IDLE, DONE, ERROR)
//   cam_rst_n_o, cam_pwdn_o  sensor reset (active-low) / power-down
//   rom_addr_o, rom_data_i   table ROM address / entry (1-cycle latency)
//   req_valid_o, req_ready_i, req_addr_o, req_data_o   SCCB write request
//   resp_valid_i, resp_nack_i                          SCCB completion
//   vsync_i                  raw asynchronous sensor vsync
//   capture_en_o             enables the downstream pixel reader
//   done_o, error_o          finished / aborted
//   err_index_o              ROM index of the entry that caused the abort
module camera_init_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 1000,
  parameter int POWERUP_WAIT_CYCLES = 100000,
  parameter int DELAY_UNIT_CYCLES   = 1024,
  parameter int ROM_ADDR_W          = 6,
  parameter int SETTLE_FRAMES       = 2,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  cam_rst_n_o,
  output logic                  cam_pwdn_o,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic [25:0]           rom_data_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [15:0]           req_addr_o,
  output logic [7:0]            req_data_o,
  input  logic                  resp_valid_i,
  input  logic                  resp_nack_i,
  input  logic                  vsync_i,
  output logic                  capture_en_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ROM_ADDR_W-1:0] err_index_o
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam int PW_W   = $clog2(POWERUP_WAIT_CYCLES) + 1;
  localparam int DLY_W  = 16 + $clog2(DELAY_UNIT_CYCLES);
  localparam int FRM_W  = $clog2(SETTLE_FRAMES) + 1;
  localparam logic [ROM_ADDR_W-1:0] ADDR_MAX = {ROM_ADDR_W{1'b1}};

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_POWERUP_WAIT,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RESP,
    S_DELAY,
    S_SETTLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [PW_W-1:0]       r_pw_cnt;
  logic [DLY_W-1:0]      r_dly_cnt;
  logic [DLY_W-1:0]      r_dly_target;
  logic [FRM_W-1:0]      r_frame_cnt;
  logic [ROM_ADDR_W-1:0] r_rom_addr;
  logic [ROM_ADDR_W-1:0] r_err_index;
  logic [15:0]           r_req_addr;
  logic [7:0]            r_req_data;
  logic                  r_cam_rst_n;
  logic                  r_cam_pwdn;
  logic                  r_capture;
  logic                  r_done;
  logic                  r_error;
  logic                  r_vs_meta;
  logic                  r_vs_sync;
  logic                  r_vs_prev;
  logic                  r_vs_fall;

  logic w_start;
  logic w_advance;
  logic w_at_max;
  logic w_hold_done;
  logic w_pw_done;
  logic w_dly_done;
  logic w_nack_retry;

  assign w_at_max    = (r_rom_addr == ADDR_MAX);
  assign w_hold_done = (r_hold_cnt == HOLD_W'(RESET_HOLD_CYCLES - 1));
  assign w_pw_done   = (r_pw_cnt == PW_W'(POWERUP_WAIT_CYCLES - 1));
  assign w_dly_done  = (r_dly_cnt == r_dly_target - DLY_W'(1));

`ifdef CAMERA_INIT_RETRY_EN
  localparam int RTRY_W = $clog2(MAX_RETRIES) + 1;
  logic [RTRY_W-1:0] r_retry;

  // A NACK is retried while retries remain; the one after the last retry aborts.
  assign w_nack_retry = (r_retry != RTRY_W'(MAX_RETRIES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retry <= '0;
    end else if (w_start) begin
      r_retry <= '0;
    end else if (r_state == S_WAIT_RESP && resp_valid_i) begin
      if (!resp_nack_i) begin
        r_retry <= '0;
      end else if (w_state_next == S_ISSUE) begin
        r_retry <= r_retry + RTRY_W'(1);
      end
    end
  end
`else
  assign w_nack_retry = 1'b0;
`endif

  // Every wait must be at least one cycle long for the terminal-count compares.
  if (RESET_HOLD_CYCLES < 1 || POWERUP_WAIT_CYCLES < 1 || DELAY_UNIT_CYCLES < 1 ||
      SETTLE_FRAMES < 1 || MAX_RETRIES < 0) begin : g_bad_params
    assert property (@(posedge clk_i) 1'b0);
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_state_next = S_RESET_HOLD;
        end
      end
      S_RESET_HOLD:   if (w_hold_done) w_state_next = S_POWERUP_WAIT;
      S_POWERUP_WAIT: if (w_pw_done) w_state_next = S_FETCH;
      S_FETCH:        w_state_next = S_DECODE;
      S_DECODE: begin
        case (rom_data_i[25:24])
          OP_WRITE: w_state_next = S_ISSUE;
          OP_DELAY: begin
            // A zero-length delay is a NOP: step straight to the next entry.
            if (rom_data_i[15:0] != 16'd0) begin
              w_state_next = S_DELAY;
            end else if (w_at_max) begin
              w_state_next = S_ERROR;
            end else begin
              w_state_next = S_FETCH;
              w_advance    = 1'b1;
            end
          end
          OP_END:   w_state_next = S_SETTLE;
          default:  w_state_next = S_ERROR;
        endcase
      end
      S_ISSUE:        if (req_ready_i) w_state_next = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (resp_valid_i) begin
          if (resp_nack_i) begin
            w_state_next = w_nack_retry ? S_ISSUE : S_ERROR;
          end else if (w_at_max) begin
            // Table ran off the end without an END entry; never wrap.
            w_state_next = S_ERROR;
          end else begin
            w_state_next = S_FETCH;
            w_advance    = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (w_dly_done) begin
          if (w_at_max) begin
            w_state_next = S_ERROR;
          end else begin
            w_state_next = S_FETCH;
            w_advance    = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (r_vs_fall && r_frame_cnt == FRM_W'(SETTLE_FRAMES - 1)) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_pw_cnt     <= '0;
      r_dly_cnt    <= '0;
      r_dly_target <= '0;
      r_frame_cnt  <= '0;
      r_rom_addr   <= '0;
      r_err_index  <= '0;
      r_req_addr   <= '0;
      r_req_data   <= '0;
      r_cam_rst_n  <= 1'b0;
      r_cam_pwdn   <= 1'b1;
      r_capture    <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_vs_meta    <= 1'b0;
      r_vs_sync    <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_vs_fall    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      r_hold_cnt <= (r_state == S_RESET_HOLD && !w_hold_done) ? r_hold_cnt + HOLD_W'(1) : '0;
      r_pw_cnt   <= (r_state == S_POWERUP_WAIT && !w_pw_done) ? r_pw_cnt + PW_W'(1) : '0;
      r_dly_cnt  <= (r_state == S_DELAY && !w_dly_done) ? r_dly_cnt + DLY_W'(1) : '0;

      if (r_state == S_SETTLE) begin
        if (r_vs_fall) r_frame_cnt <= r_frame_cnt + FRM_W'(1);
      end else begin
        r_frame_cnt <= '0;
      end

      // Two-flop synchronizer, then a registered falling-edge pulse.
      r_vs_meta <= vsync_i;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_vs_fall <= r_vs_prev & ~r_vs_sync;

      if (w_start) begin
        r_cam_rst_n <= 1'b0;
        r_cam_pwdn  <= 1'b0;
        r_capture   <= 1'b0;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
      end

      if (r_state == S_RESET_HOLD && w_hold_done) r_cam_rst_n <= 1'b1;

      if (r_state == S_POWERUP_WAIT && w_pw_done) begin
        r_rom_addr <= '0;
      end else if (w_advance) begin
        r_rom_addr <= r_rom_addr + ROM_ADDR_W'(1);
      end

      if (r_state == S_DECODE) begin
        r_req_addr   <= rom_data_i[23:8];
        r_req_data   <= rom_data_i[7:0];
        r_dly_target <= DLY_W'(rom_data_i[15:0]) * DLY_W'(DELAY_UNIT_CYCLES);
      end

      if (r_state == S_SETTLE && w_state_next == S_DONE) begin
        r_capture <= 1'b1;
        r_done    <= 1'b1;
      end

      if (r_state != S_ERROR && w_state_next == S_ERROR) begin
        r_error     <= 1'b1;
        r_err_index <= r_rom_addr;
        r_capture   <= 1'b0;
      end
    end
  end

  // A completion in the very cycle the request is accepted is a master bug.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(req_valid_o && req_ready_i && resp_valid_i));

  assign req_valid_o  = (r_state == S_ISSUE);
  assign req_addr_o   = r_req_addr;
  assign req_data_o   = r_req_data;
  assign rom_addr_o   = r_rom_addr;
  assign cam_rst_n_o  = r_cam_rst_n;
  assign cam_pwdn_o   = r_cam_pwdn;
  assign capture_en_o = r_capture;
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign err_index_o  = r_err_index;

endmodule
